axis_read_cfg_seq: RTL and testbench

- Upstream config master for the read-stream engine's cfg port. Accepts read descriptors (byte address, length in stream words) over a valid/ready handshake and queues them.
- For each descriptor, emits the 3-beat config sequence on the cfg bus: select beat, then address, then length.
- Lets a CPU/register block queue several reads without polling the engine's cfg_ready stall.

---
 rtl/axis_read_cfg_seq_pkg.sv | 31 +++
 rtl/axis_desc_fifo.sv | 71 +++++++
 rtl/axis_read_cfg_seq.sv | 170 +++++++++++++++++
 tb/tb_axis_read_cfg_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_read_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// axis_read_cfg_seq_pkg
//   Shared definitions for the read-stream cfg sequencer:
//   - default cfg register addresses for the select beat and the data beats
//   - number of data beats that follow the select beat
//   - one-hot state encoding of the cfg sequencer
// ---------------------------------------------------------------------------
package axis_read_cfg_seq_pkg;

    // Default cfg_addr codes understood by the read-stream engine.
    localparam int unsigned DEF_CFG_ADDR = 23;  // select beat (carries the ID)
    localparam int unsigned DEF_CFG_DATA = 24;  // address and length beats

    // Data beats per sequence after the select beat (address, length).
    localparam int unsigned CFG_NB = 2;

    // One-hot bit positions of the sequencer states.
    localparam int unsigned ST_IDLE_BIT = 0;
    localparam int unsigned ST_ID_BIT   = 1;
    localparam int unsigned ST_ADR_BIT  = 2;
    localparam int unsigned ST_LEN_BIT  = 3;

    // Each value sets exactly the bit named by the matching *_BIT index.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ID   = 4'b0010,
        S_ADR  = 4'b0100,
        S_LEN  = 4'b1000
    } cfg_state_t;

endpackage : axis_read_cfg_seq_pkg

// File: rtl/axis_desc_fifo.sv
// ---------------------------------------------------------------------------
// axis_desc_fifo
//   Synchronous FIFO, depth 2**AWIDTH, first-word fall-through read port.
//   Pointers carry one extra MSB so full and empty can be told apart.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (pointers only)
//   push     in   write wr_data (ignored when full)
//   wr_data  in   WIDTH write word
//   pop      in   drop the head entry (ignored when empty)
//   rd_data  out  WIDTH head entry, valid while empty=0
//   count    out  AWIDTH+1 number of stored entries
//   full     out  no free entry
//   empty    out  no stored entry
// ---------------------------------------------------------------------------
module axis_desc_fifo #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]  wr_ptr;
    logic [AWIDTH:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Same index with different wrap bit means the writer is a full lap ahead.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                     (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AWIDTH-1:0]];

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AWIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule : axis_desc_fifo

// File: rtl/axis_read_cfg_seq.sv
// ---------------------------------------------------------------------------
// axis_read_cfg_seq
//   Queues read descriptors {address, length} and, for each one, drives the
//   3-beat config sequence to the read-stream engine's cfg port:
//     select (CFG_ADDR, CFG_ID) -> address (CFG_DATA, addr) -> length (CFG_DATA, len)
//   Zero-length descriptors are accepted and dropped.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both high. Once cfg_valid is raised it stays high, and
//   cfg_addr/cfg_data stay stable, until the beat transfers. desc_ready does
//   not depend on desc_valid.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   desc_address   read start byte address
//   desc_length    read length in stream words
//   desc_valid/desc_ready  descriptor handshake (desc_ready = queue not full)
//   cfg_addr/cfg_data/cfg_valid/cfg_ready  registered cfg beat output
//   pending        queued descriptors plus the one being sent
//   idle           pending == 0
// ---------------------------------------------------------------------------
module axis_read_cfg_seq
    import axis_read_cfg_seq_pkg::*;
#(
    parameter int unsigned DESC_AWIDTH = 2,
    parameter int unsigned CFG_ID      = 1,
    parameter int unsigned CFG_ADDR    = DEF_CFG_ADDR,
    parameter int unsigned CFG_DATA    = DEF_CFG_DATA,
    parameter int unsigned CFG_AWIDTH  = 5,
    parameter int unsigned CFG_DWIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CFG_DWIDTH-1:0]  desc_address,
    input  logic [CFG_DWIDTH-1:0]  desc_length,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    output logic [CFG_AWIDTH-1:0]  cfg_addr,
    output logic [CFG_DWIDTH-1:0]  cfg_data,
    output logic                   cfg_valid,
    input  logic                   cfg_ready,
    output logic [DESC_AWIDTH:0]   pending,
    output logic                   idle
);

    localparam int unsigned PW = DESC_AWIDTH + 1;
    localparam int unsigned EW = 2 * CFG_DWIDTH;

    cfg_state_t              state_q;
    cfg_state_t              state_d;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PW-1:0]           fifo_count;
    logic [EW-1:0]           fifo_rd_data;
    logic [CFG_DWIDTH-1:0]   hold_addr;
    logic [CFG_DWIDTH-1:0]   hold_len;
    logic [CFG_AWIDTH-1:0]   cfg_addr_d;
    logic [CFG_DWIDTH-1:0]   cfg_data_d;
    logic                    cfg_valid_d;
    logic [PW-1:0]           pending_d;

    assign desc_ready = ~fifo_full;
    // Zero-length descriptors complete the handshake but never enter the queue.
    assign push       = desc_valid & ~fifo_full & (desc_length != '0);

    axis_desc_fifo #(
        .WIDTH  (EW),
        .AWIDTH (DESC_AWIDTH)
    ) u_desc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({desc_address, desc_length}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and next-output logic. The cfg outputs are registered, so the
    // value for the next beat is prepared here and loaded at the edge where
    // the state advances; without cfg_ready everything holds.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cfg_addr_d  = cfg_addr;
        cfg_data_d  = cfg_data;
        cfg_valid_d = cfg_valid;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_d     = S_ID;
                    cfg_addr_d  = CFG_AWIDTH'(CFG_ADDR);
                    cfg_data_d  = CFG_DWIDTH'(CFG_ID);
                    cfg_valid_d = 1'b1;
                end
            end
            S_ID: begin
                if (cfg_ready) begin
                    state_d    = S_ADR;
                    cfg_addr_d = CFG_AWIDTH'(CFG_DATA);
                    cfg_data_d = hold_addr;
                end
            end
            S_ADR: begin
                if (cfg_ready) begin
                    state_d    = S_LEN;
                    cfg_addr_d = CFG_AWIDTH'(CFG_DATA);
                    cfg_data_d = hold_len;
                end
            end
            S_LEN: begin
                if (cfg_ready) begin
                    if (!fifo_empty) begin
                        // Next descriptor starts with no bubble.
                        pop        = 1'b1;
                        state_d    = S_ID;
                        cfg_addr_d = CFG_AWIDTH'(CFG_ADDR);
                        cfg_data_d = CFG_DWIDTH'(CFG_ID);
                    end else begin
                        state_d     = S_IDLE;
                        cfg_addr_d  = '0;
                        cfg_data_d  = '0;
                        cfg_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle.
                state_d     = S_IDLE;
                cfg_addr_d  = '0;
                cfg_data_d  = '0;
                cfg_valid_d = 1'b0;
            end
        endcase
    end

    // pending tracks the queue count after this edge plus the descriptor the
    // sequencer owns; the in-flight one is released by the length beat.
    assign pending_d = fifo_count + PW'(push) - PW'(pop) + PW'(state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
            hold_addr <= '0;
            hold_len  <= '0;
            pending   <= '0;
            idle      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cfg_addr  <= cfg_addr_d;
            cfg_data  <= cfg_data_d;
            cfg_valid <= cfg_valid_d;
            pending   <= pending_d;
            idle      <= (pending_d == '0);
            if (pop) begin
                hold_addr <= fifo_rd_data[EW-1:CFG_DWIDTH];
                hold_len  <= fifo_rd_data[CFG_DWIDTH-1:0];
            end
        end
    end

endmodule : axis_read_cfg_seq

// File: tb/tb_axis_read_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_axis_read_cfg_seq
//   Directed and randomized descriptors against a descriptor-level model:
//   every accepted non-zero descriptor expands to three expected beats, and
//   pending / desc_ready / idle follow from counts of accepted, started and
//   completed descriptors.
// ---------------------------------------------------------------------------
module tb_axis_read_cfg_seq;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = AW + DW;
  localparam logic [AW-1:0] SEL_A = 5'd23;
  localparam logic [AW-1:0] DAT_A = 5'd24;
  localparam logic [DW-1:0] ID_W  = 32'd1;
  localparam int QDEPTH = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] desc_address = '0;
  logic [DW-1:0] desc_length = '0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready = 1'b1;
  logic [2:0]    pending;
  logic          idle;

  always #5 clk = ~clk;

  axis_read_cfg_seq #(
    .DESC_AWIDTH (2),
    .CFG_ID      (1),
    .CFG_ADDR    (23),
    .CFG_DATA    (24),
    .CFG_AWIDTH  (AW),
    .CFG_DWIDTH  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .desc_address (desc_address),
    .desc_length  (desc_length),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .pending      (pending),
    .idle         (idle)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];
  int accepted = 0;   // non-zero descriptors accepted since reset
  int started = 0;    // descriptors whose select beat has appeared
  int completed = 0;  // descriptors whose length beat transferred
  logic prev_valid = 1'b0;
  logic prev_xfer = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: runs on the falling edge, between DUT updates and bench drives.
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] exp_b;
    cur = {cfg_addr, cfg_data};
    if (!rst_n) begin
      exp_q.delete();
      accepted = 0;
      started = 0;
      completed = 0;
      prev_valid = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (prev_valid && !prev_xfer) begin
        check("stall_valid_held", 64'(cfg_valid), 64'(1'b1));
        check("stall_beat_held", 64'(cur), 64'(prev_beat));
      end
      // A fresh beat at a descriptor boundary of the expected stream is a select.
      if (cfg_valid && (!prev_valid || prev_xfer) && exp_q.size() > 0 && (exp_q.size() % 3) == 0)
        started++;
      check("desc_ready", 64'(desc_ready), 64'((accepted - started) < QDEPTH));
      check("pending", 64'(pending), 64'(accepted - completed));
      check("idle", 64'(idle), 64'(accepted == completed));
      if (cfg_valid && cfg_ready) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'(1'b1));
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("beat", 64'(cur), 64'(exp_b));
          if ((exp_q.size() % 3) == 0) completed++;
        end
      end
      if (desc_valid && desc_ready && desc_length != '0) begin
        exp_q.push_back({SEL_A, ID_W});
        exp_q.push_back({DAT_A, desc_address});
        exp_q.push_back({DAT_A, desc_length});
        accepted++;
      end
      prev_valid = cfg_valid;
      prev_xfer = cfg_valid && cfg_ready;
      prev_beat = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one descriptor and hold it until accepted. With rnd set, cfg_ready
  // is re-randomized while waiting so a full queue can drain.
  task automatic push_desc(input logic [DW-1:0] a, input logic [DW-1:0] l, input bit rnd);
    int n;
    n = 0;
    desc_address = a;
    desc_length = l;
    desc_valid = 1'b1;
    @(negedge clk);
    while (!desc_ready && n < 200) begin
      tick();
      if (rnd) cfg_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n++;
    end
    check("desc_accept_in_time", 64'(desc_ready), 64'(1'b1));
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cfg_ready = 1'b1;
    @(negedge clk);
    while (!(idle && !cfg_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(idle && !cfg_valid), 64'(1'b1));
    tick();
  endtask

  // Wait (at posedge+1) for the address beat carrying addr to be on the bus.
  task automatic wait_addr_beat(input logic [DW-1:0] addr);
    int n;
    n = 0;
    while (!(cfg_valid && cfg_addr == DAT_A && cfg_data == addr) && n < 50) begin
      tick();
      n++;
    end
    check("addr_beat_seen", 64'(cfg_valid && cfg_addr == DAT_A && cfg_data == addr), 64'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] l;
    logic [DW-1:0] la;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_valid", 64'(cfg_valid), 64'(1'b0));
    check("rst_cfg_addr", 64'(cfg_addr), 64'(0));
    check("rst_cfg_data", 64'(cfg_data), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_idle", 64'(idle), 64'(1'b1));
    rst_n = 1'b1;
    tick();
    check("rst_desc_ready", 64'(desc_ready), 64'(1'b1));

    // Single descriptor, cfg_ready high: select visible after handshake edge + 1.
    cfg_ready = 1'b1;
    push_desc(32'h1000_0000, 32'd256, 1'b0);
    @(negedge clk);
    check("single_not_early", 64'(cfg_valid), 64'(1'b0));
    @(negedge clk);
    check("single_sel", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, SEL_A, ID_W}));
    @(negedge clk);
    check("single_adr", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, DAT_A, 32'h1000_0000}));
    @(negedge clk);
    check("single_len", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, DAT_A, 32'd256}));
    @(negedge clk);
    check("single_done_valid", 64'(cfg_valid), 64'(1'b0));
    check("single_done_idle", 64'(idle), 64'(1'b1));
    wait_idle();

    // Back-pressure on the address beat for 5 cycles.
    a = $urandom();
    push_desc(a, 32'd17, 1'b0);
    wait_addr_beat(a);
    cfg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_adr_hold", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, DAT_A, a}));
      tick();
    end
    cfg_ready = 1'b1;
    wait_idle();

    // Queue full: 5 accepted (one in the sequencer), sixth refused.
    cfg_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_desc($urandom(), 32'($urandom_range(1, 4096)), 1'b0);
    @(negedge clk);
    check("full_desc_ready", 64'(desc_ready), 64'(1'b0));
    check("full_pending", 64'(pending), 64'(5));
    desc_address = $urandom();
    desc_length = 32'd9;
    desc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("full_refuse", 64'(desc_ready), 64'(1'b0));
    end
    tick();
    desc_valid = 1'b0;
    cfg_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("full_no_gap", 64'(cfg_valid), 64'(1'b1));
    end
    wait_idle();

    // Zero-length descriptor between two real ones.
    cfg_ready = 1'b1;
    push_desc($urandom(), 32'd5, 1'b0);
    push_desc($urandom(), 32'd0, 1'b0);
    push_desc($urandom(), 32'd7, 1'b0);
    wait_idle();

    // Push lands on the same edge as the length beat, with one queued.
    cfg_ready = 1'b0;
    la = 32'd33;
    push_desc($urandom(), la, 1'b0);
    push_desc($urandom(), 32'd44, 1'b0);
    cfg_ready = 1'b1;
    tick();
    tick();
    desc_address = $urandom();
    desc_length = 32'd55;
    desc_valid = 1'b1;
    @(negedge clk);
    check("sim_len_beat", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, DAT_A, la}));
    check("sim_desc_ready", 64'(desc_ready), 64'(1'b1));
    tick();
    desc_valid = 1'b0;
    @(negedge clk);
    check("sim_pending_same", 64'(pending), 64'(2));
    check("sim_next_sel", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, SEL_A, ID_W}));
    wait_idle();

    // Randomized descriptors and cfg back-pressure.
    for (int i = 0; i < 40; i++) begin
      cfg_ready = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
      push_desc($urandom(), l, 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        cfg_ready = ($urandom_range(0, 1) == 1);
        tick();
      end
    end
    wait_idle();

    // Reset during the address beat, with another descriptor queued.
    cfg_ready = 1'b0;
    a = $urandom();
    push_desc(a, 32'd99, 1'b0);
    push_desc($urandom(), 32'd98, 1'b0);
    cfg_ready = 1'b1;
    wait_addr_beat(a);
    cfg_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_async", 64'(cfg_valid), 64'(1'b0));
    @(negedge clk);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    cfg_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", 64'(idle), 64'(1'b1));
    check("rst_mid_pending", 64'(pending), 64'(0));
    check("rst_mid_desc_ready", 64'(desc_ready), 64'(1'b1));
    check("rst_mid_cfg_valid", 64'(cfg_valid), 64'(1'b0));
    tick();
    push_desc($urandom(), 32'd3, 1'b0);
    wait_idle();

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axis_read_cfg_seq
